urv_decode_sb: RTL and testbench



---
 rtl/urv_decode_sb.sv | 171 +++++++++++++++++
 tb/tb_urv_decode_sb.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/urv_decode_sb.sv
// Decode stage with per-register latency scoreboard: decodes the fetched word into registered execute fields.
// Latency: 1 cycle fetch-to-execute; backpressure stalls issue while a source is busy or execute is full.
module urv_decode_sb #(
    parameter int g_num_regs      = 32,
    parameter int g_load_latency  = 2,
    parameter int g_mul_latency   = 2,
    parameter int g_shift_latency = 2,
    parameter int g_with_hw_div   = 0,
    parameter int g_with_hw_mulh  = 0
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [31:0] f_ir_i,
    input  logic [31:0] f_pc_i,
    input  logic        f_valid_i,
    output logic        d_ready_o,
    input  logic        d_kill_i,
    input  logic        x_ready_i,
    output logic [4:0]  rf_rs1_o,
    output logic [4:0]  rf_rs2_o,
    output logic        x_valid_o,
    output logic [31:0] x_pc_o,
    output logic [4:0]  x_rs1_o,
    output logic [4:0]  x_rs2_o,
    output logic [4:0]  x_rd_o,
    output logic [4:0]  x_opcode_o,
    output logic [2:0]  x_fun_o,
    output logic [31:0] x_imm_o,
    output logic [2:0]  x_rd_source_o,
    output logic        x_rd_write_o,
    output logic        x_is_load_o,
    output logic        x_is_store_o,
    output logic        x_is_undef_o
);
    localparam bit RV32E = (g_num_regs == 16);
    localparam int AW    = RV32E ? 4 : 5;

    localparam logic [4:0] OPC_OP_IMM = 5'b00100, OPC_LUI = 5'b01101, OPC_AUIPC = 5'b00101,
                           OPC_OP = 5'b01100, OPC_JAL = 5'b11011, OPC_JALR = 5'b11001,
                           OPC_BRANCH = 5'b11000, OPC_LOAD = 5'b00000, OPC_STORE = 5'b01000,
                           OPC_SYSTEM = 5'b11100;
    localparam logic [2:0] SRC_ALU = 3'b000, SRC_MULTIPLY = 3'b001, SRC_SHIFTER = 3'b010,
                           SRC_DIVIDE = 3'b011, SRC_CSR = 3'b100, SRC_MULH = 3'b111;
    localparam logic [2:0] LD_CNT  = 3'(g_load_latency - 1);
    localparam logic [2:0] MUL_CNT = 3'(g_mul_latency - 1);
    localparam logic [2:0] SH_CNT  = 3'(g_shift_latency - 1);

    logic [2:0]  busy [g_num_regs];
    logic [4:0]  opc, rs1, rs2, rd;
    logic [2:0]  fun3, fun, src, sb_cnt;
    logic [31:0] imm;
    logic        rs1_used, rs2_used, is_load, is_store, is_shift, is_muldiv, is_mul, is_mulh, is_div;
    logic        rd_write_raw, reg_bad, undef, rs1_busy, rs2_busy, hazard, issue, sb_set;
    logic [1:0]  ir_unused;

    assign opc       = f_ir_i[6:2];
    assign fun3      = f_ir_i[14:12];
    assign rs1       = f_ir_i[19:15];
    assign rs2       = f_ir_i[24:20];
    assign rd        = f_ir_i[11:7];
    assign rf_rs1_o  = rs1;
    assign rf_rs2_o  = rs2;
    assign ir_unused = f_ir_i[1:0];

    always_comb begin
        rs1_used  = !(opc == OPC_LUI || opc == OPC_AUIPC || opc == OPC_JAL ||
                      (opc == OPC_SYSTEM && fun3[2]));
        rs2_used  = (opc == OPC_OP || opc == OPC_STORE || opc == OPC_BRANCH);
        is_load   = (opc == OPC_LOAD);
        is_store  = (opc == OPC_STORE);
        is_muldiv = (opc == OPC_OP) && f_ir_i[25];
        is_mul    = is_muldiv && (fun3 == 3'b000);
        is_mulh   = is_muldiv && !fun3[2] && (fun3 != 3'b000);
        is_div    = is_muldiv && fun3[2];
        is_shift  = (fun3 == 3'b001 || fun3 == 3'b101) &&
                    (opc == OPC_OP_IMM || (opc == OPC_OP && !f_ir_i[25]));

        rd_write_raw = 1'b0;
        case (opc)
            OPC_OP_IMM, OPC_OP, OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC: rd_write_raw = (rd != 5'd0);
            OPC_SYSTEM: rd_write_raw = (rd != 5'd0) && (fun3 != 3'b000);
            default:    rd_write_raw = 1'b0;
        endcase

        // The upper register half does not exist on RV32E; such words are undefined and write nothing.
        reg_bad = RV32E && ((rs1_used && rs1[4]) || (rs2_used && rs2[4]) ||
                            ((rd_write_raw || is_load) && rd[4]));
        undef   = (is_mulh && g_with_hw_mulh == 0) || (is_div && g_with_hw_div == 0) || reg_bad;

        imm = 32'd0;
        case (opc)
            OPC_LUI, OPC_AUIPC:           imm = {f_ir_i[31:12], 12'd0};
            OPC_OP_IMM, OPC_LOAD, OPC_JALR: imm = {{21{f_ir_i[31]}}, f_ir_i[30:20]};
            OPC_STORE:  imm = {{21{f_ir_i[31]}}, f_ir_i[30:25], f_ir_i[11:7]};
            OPC_BRANCH: imm = {{20{f_ir_i[31]}}, f_ir_i[7], f_ir_i[30:25], f_ir_i[11:8], 1'b0};
            OPC_JAL:    imm = {{12{f_ir_i[31]}}, f_ir_i[19:12], f_ir_i[20], f_ir_i[30:21], 1'b0};
            default:    imm = 32'd0;
        endcase

        fun = (opc == OPC_JAL || opc == OPC_JALR || opc == OPC_LUI || opc == OPC_AUIPC) ? 3'b000 : fun3;

        if (is_shift)                src = SRC_SHIFTER;
        else if (opc == OPC_SYSTEM)  src = SRC_CSR;
        else if (is_mul)             src = SRC_MULTIPLY;
        else if (is_mulh)            src = SRC_MULH;
        else if (is_div)             src = SRC_DIVIDE;
        else                         src = SRC_ALU;

        sb_cnt = 3'd0;
        if (is_load)                sb_cnt = LD_CNT;
        else if (is_shift)          sb_cnt = SH_CNT;
        else if (is_mul || is_mulh) sb_cnt = MUL_CNT;
    end

    assign rs1_busy  = !(RV32E && rs1[4]) && (busy[rs1[AW-1:0]] != 3'd0);
    assign rs2_busy  = !(RV32E && rs2[4]) && (busy[rs2[AW-1:0]] != 3'd0);
    assign hazard    = f_valid_i && ((rs1_used && rs1_busy) || (rs2_used && rs2_busy));
    assign d_ready_o = rst_n_i && !d_kill_i && (!x_valid_o || x_ready_i) && !hazard;
    assign issue     = f_valid_i && d_ready_o;
    // Loads track their destination even though the writeback path, not x_rd_write_o, retires them.
    assign sb_set    = issue && (rd_write_raw || is_load) && (rd != 5'd0) && !reg_bad && (sb_cnt != 3'd0);

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            x_valid_o     <= 1'b0;
            x_pc_o        <= 32'd0;
            x_rs1_o       <= 5'd0;
            x_rs2_o       <= 5'd0;
            x_rd_o        <= 5'd0;
            x_opcode_o    <= 5'd0;
            x_fun_o       <= 3'd0;
            x_imm_o       <= 32'd0;
            x_rd_source_o <= 3'd0;
            x_rd_write_o  <= 1'b0;
            x_is_load_o   <= 1'b0;
            x_is_store_o  <= 1'b0;
            x_is_undef_o  <= 1'b0;
        end else if (d_kill_i) begin
            x_valid_o <= 1'b0;
        end else if (issue) begin
            x_valid_o     <= 1'b1;
            x_pc_o        <= f_pc_i;
            x_rs1_o       <= rs1;
            x_rs2_o       <= rs2;
            x_rd_o        <= rd;
            x_opcode_o    <= opc;
            x_fun_o       <= fun;
            x_imm_o       <= imm;
            x_rd_source_o <= src;
            x_rd_write_o  <= rd_write_raw && !reg_bad;
            x_is_load_o   <= is_load;
            x_is_store_o  <= is_store;
            x_is_undef_o  <= undef;
        end else if (x_ready_i) begin
            x_valid_o <= 1'b0;
        end
    end

    // Kill leaves the counters alone so killed producers age out and stalls stay conservative.
    always_ff @(posedge clk_i) begin
        busy[0] <= 3'd0;
        for (int i = 1; i < g_num_regs; i++) begin
            if (!rst_n_i)
                busy[i] <= 3'd0;
            else if (sb_set && rd[AW-1:0] == AW'(i))
                busy[i] <= sb_cnt;
            else if (x_ready_i && busy[i] != 3'd0)
                busy[i] <= busy[i] - 3'd1;
        end
    end
endmodule

// File: tb/tb_urv_decode_sb.sv
// Directed bench: decode table on the default core, then scoreboard timing corner cases on three configurations.
module tb_urv_decode_sb;
    logic        clk = 1'b0;
    logic        rst_n, f_valid, d_kill, x_ready;
    logic [31:0] f_ir, f_pc;

    logic        a_rdy, b_rdy, c_rdy, a_xv, b_xv, c_xv;
    logic [4:0]  a_r1, b_r1, c_r1, a_r2, b_r2, c_r2;
    logic [31:0] a_pc, b_pc, c_pc, a_imm, b_imm, c_imm;
    logic [4:0]  a_xr1, b_xr1, c_xr1, a_xr2, b_xr2, c_xr2, a_rd, b_rd, c_rd, a_opc, b_opc, c_opc;
    logic [2:0]  a_fun, b_fun, c_fun, a_src, b_src, c_src;
    logic        a_wr, b_wr, c_wr, a_ld, b_ld, c_ld, a_st, b_st, c_st, a_un, b_un, c_un;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] LW5  = 32'h0000A283;  // lw   x5,0(x1)
    localparam logic [31:0] ADD6 = 32'h00228333;  // add  x6,x5,x2
    localparam logic [31:0] ADD7 = 32'h002083B3;  // add  x7,x1,x2

    urv_decode_sb u_a (
        .clk_i(clk), .rst_n_i(rst_n), .f_ir_i(f_ir), .f_pc_i(f_pc), .f_valid_i(f_valid),
        .d_ready_o(a_rdy), .d_kill_i(d_kill), .x_ready_i(x_ready), .rf_rs1_o(a_r1), .rf_rs2_o(a_r2),
        .x_valid_o(a_xv), .x_pc_o(a_pc), .x_rs1_o(a_xr1), .x_rs2_o(a_xr2), .x_rd_o(a_rd),
        .x_opcode_o(a_opc), .x_fun_o(a_fun), .x_imm_o(a_imm), .x_rd_source_o(a_src),
        .x_rd_write_o(a_wr), .x_is_load_o(a_ld), .x_is_store_o(a_st), .x_is_undef_o(a_un));

    urv_decode_sb #(.g_load_latency(4)) u_b (
        .clk_i(clk), .rst_n_i(rst_n), .f_ir_i(f_ir), .f_pc_i(f_pc), .f_valid_i(f_valid),
        .d_ready_o(b_rdy), .d_kill_i(d_kill), .x_ready_i(x_ready), .rf_rs1_o(b_r1), .rf_rs2_o(b_r2),
        .x_valid_o(b_xv), .x_pc_o(b_pc), .x_rs1_o(b_xr1), .x_rs2_o(b_xr2), .x_rd_o(b_rd),
        .x_opcode_o(b_opc), .x_fun_o(b_fun), .x_imm_o(b_imm), .x_rd_source_o(b_src),
        .x_rd_write_o(b_wr), .x_is_load_o(b_ld), .x_is_store_o(b_st), .x_is_undef_o(b_un));

    urv_decode_sb #(.g_num_regs(16)) u_c (
        .clk_i(clk), .rst_n_i(rst_n), .f_ir_i(f_ir), .f_pc_i(f_pc), .f_valid_i(f_valid),
        .d_ready_o(c_rdy), .d_kill_i(d_kill), .x_ready_i(x_ready), .rf_rs1_o(c_r1), .rf_rs2_o(c_r2),
        .x_valid_o(c_xv), .x_pc_o(c_pc), .x_rs1_o(c_xr1), .x_rs2_o(c_xr2), .x_rd_o(c_rd),
        .x_opcode_o(c_opc), .x_fun_o(c_fun), .x_imm_o(c_imm), .x_rd_source_o(c_src),
        .x_rd_write_o(c_wr), .x_is_load_o(c_ld), .x_is_store_o(c_st), .x_is_undef_o(c_un));

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ir;
        logic [4:0]  opc;
        logic [2:0]  fun;
        logic [31:0] imm;
        logic [2:0]  src;
        logic        wr, ld, st, un;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0; f_valid = 1'b0; d_kill = 1'b0; x_ready = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        tbl[0]  = '{32'hFFC0A283, 5'b00000, 3'b010, 32'hFFFFFFFC, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0}; // lw x5,-4(x1)
        tbl[1]  = '{32'h00228333, 5'b01100, 3'b000, 32'h00000000, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0}; // add x6,x5,x2
        tbl[2]  = '{32'h002093B3, 5'b01100, 3'b001, 32'h00000000, 3'b010, 1'b1, 1'b0, 1'b0, 1'b0}; // sll x7,x1,x2
        tbl[3]  = '{32'h4041D413, 5'b00100, 3'b101, 32'h00000404, 3'b010, 1'b1, 1'b0, 1'b0, 1'b0}; // srai x8,x3,4
        tbl[4]  = '{32'h022084B3, 5'b01100, 3'b000, 32'h00000000, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0}; // mul
        tbl[5]  = '{32'h022094B3, 5'b01100, 3'b001, 32'h00000000, 3'b111, 1'b1, 1'b0, 1'b0, 1'b1}; // mulh
        tbl[6]  = '{32'h0220C4B3, 5'b01100, 3'b100, 32'h00000000, 3'b011, 1'b1, 1'b0, 1'b0, 1'b1}; // div
        tbl[7]  = '{32'h0020A423, 5'b01000, 3'b010, 32'h00000008, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0}; // sw x2,8(x1)
        tbl[8]  = '{32'hFE208CE3, 5'b11000, 3'b000, 32'hFFFFFFF8, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0}; // beq -8
        tbl[9]  = '{32'h010000EF, 5'b11011, 3'b000, 32'h00000010, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0}; // jal x1,16
        tbl[10] = '{32'h12345537, 5'b01101, 3'b000, 32'h12345000, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0}; // lui x10
        tbl[11] = '{32'h340095F3, 5'b11100, 3'b001, 32'h00000000, 3'b100, 1'b1, 1'b0, 1'b0, 1'b0}; // csrrw x11
        tbl[12] = '{32'h00000013, 5'b00100, 3'b000, 32'h00000000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0}; // nop
        tbl[13] = '{32'h00001617, 5'b00101, 3'b000, 32'h00001000, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0}; // auipc x12,1

        // Reset state with a valid word presented
        rst_n = 1'b0; d_kill = 1'b0; x_ready = 1'b1; f_valid = 1'b1; f_ir = LW5; f_pc = 32'h80;
        tick();
        tick();
        @(negedge clk);
        chk("rst_ready", {31'd0, a_rdy}, 32'd0);
        chk("rst_xvalid", {31'd0, a_xv}, 32'd0);
        chk("rst_imm", a_imm, 32'd0);
        chk("rst_pc", a_pc, 32'd0);
        chk("rst_isload", {31'd0, a_ld}, 32'd0);
        tick();
        rst_n = 1'b1;

        // Decode table on the default configuration
        for (int i = 0; i < 14; i++) begin
            logic [31:0] ir;
            logic [31:0] pc;
            ir = tbl[i].ir;
            pc = 32'h100 + 32'(i) * 4;
            f_ir = ir; f_pc = pc; f_valid = 1'b1;
            @(negedge clk);
            chk("tbl_ready", {31'd0, a_rdy}, 32'd1);
            tick();
            f_valid = 1'b0;
            @(negedge clk);
            chk("tbl_valid", {31'd0, a_xv}, 32'd1);
            chk("tbl_pc", a_pc, pc);
            chk("tbl_rd", {27'd0, a_rd}, {27'd0, ir[11:7]});
            chk("tbl_opcode", {27'd0, a_opc}, {27'd0, tbl[i].opc});
            chk("tbl_fun", {29'd0, a_fun}, {29'd0, tbl[i].fun});
            chk("tbl_imm", a_imm, tbl[i].imm);
            chk("tbl_src", {29'd0, a_src}, {29'd0, tbl[i].src});
            chk("tbl_rdwrite", {31'd0, a_wr}, {31'd0, tbl[i].wr});
            chk("tbl_isload", {31'd0, a_ld}, {31'd0, tbl[i].ld});
            chk("tbl_isstore", {31'd0, a_st}, {31'd0, tbl[i].st});
            chk("tbl_undef", {31'd0, a_un}, {31'd0, tbl[i].un});
            tick();
        end

        // Load-use: 1 stall on default, 3 stalls with load latency 4
        do_reset();
        f_ir = LW5; f_valid = 1'b1;
        @(negedge clk);
        chk("lu_ready_lw_a", {31'd0, a_rdy}, 32'd1);
        chk("lu_ready_lw_b", {31'd0, b_rdy}, 32'd1);
        tick();
        f_ir = ADD6;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("lu_stall_a", {31'd0, a_rdy}, (c >= 1) ? 32'd1 : 32'd0);
            chk("lu_stall_b", {31'd0, b_rdy}, (c >= 3) ? 32'd1 : 32'd0);
            chk("lu_xvalid_a", {31'd0, a_xv}, (c != 1) ? 32'd1 : 32'd0);
            tick();
        end
        @(negedge clk);
        chk("lu_add_rd_a", {27'd0, a_rd}, 32'd6);
        f_ir = LW5;
        tick();
        f_ir = ADD7;
        @(negedge clk);
        chk("indep_ready_b", {31'd0, b_rdy}, 32'd1);
        tick();

        // Load then execute backpressure for 3 cycles
        do_reset();
        f_ir = LW5; f_pc = 32'h200; f_valid = 1'b1;
        tick();
        f_ir = ADD6; f_pc = 32'h204; x_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("bp_xvalid", {31'd0, a_xv}, 32'd1);
            chk("bp_rd", {27'd0, a_rd}, 32'd5);
            chk("bp_pc", a_pc, 32'h200);
            chk("bp_isload", {31'd0, a_ld}, 32'd1);
            chk("bp_ready", {31'd0, a_rdy}, 32'd0);
            tick();
        end
        x_ready = 1'b1;
        @(negedge clk);
        chk("bp_frozen_ready", {31'd0, a_rdy}, 32'd0);
        tick();
        @(negedge clk);
        chk("bp_release_ready", {31'd0, a_rdy}, 32'd1);
        chk("bp_release_xvalid", {31'd0, a_xv}, 32'd0);
        tick();
        @(negedge clk);
        chk("bp_consumer_rd", {27'd0, a_rd}, 32'd6);
        chk("bp_consumer_pc", a_pc, 32'h204);

        // RV32E: upper registers are undefined and leave no scoreboard entry
        do_reset();
        f_ir = 32'h002088B3; f_valid = 1'b1;   // add x17,x1,x2
        tick();
        f_ir = 32'h002098B3;                   // sll x17,x1,x2
        @(negedge clk);
        chk("e_add_undef", {31'd0, c_un}, 32'd1);
        chk("e_add_rdwrite", {31'd0, c_wr}, 32'd0);
        chk("e_add_undef_rv32", {31'd0, a_un}, 32'd0);
        chk("e_add_rdwrite_rv32", {31'd0, a_wr}, 32'd1);
        chk("e_sll_ready", {31'd0, c_rdy}, 32'd1);
        tick();
        f_ir = 32'h00288333;                   // add x6,x17,x2
        @(negedge clk);
        chk("e_sll_undef", {31'd0, c_un}, 32'd1);
        chk("e_sll_rdwrite", {31'd0, c_wr}, 32'd0);
        chk("e_consumer_ready", {31'd0, c_rdy}, 32'd1);
        tick();

        // x0 destination never busy; kill clears execute but not the scoreboard
        do_reset();
        f_ir = 32'h0000A003; f_valid = 1'b1;   // lw x0,0(x1)
        tick();
        f_ir = 32'h00000333;                   // add x6,x0,x0
        @(negedge clk);
        chk("x0_ready", {31'd0, a_rdy}, 32'd1);
        tick();
        f_ir = LW5;
        tick();
        f_valid = 1'b0; d_kill = 1'b1;
        @(negedge clk);
        chk("kill_ready", {31'd0, a_rdy}, 32'd0);
        tick();
        d_kill = 1'b0; f_valid = 1'b1; f_ir = ADD6;
        @(negedge clk);
        chk("kill_xvalid", {31'd0, a_xv}, 32'd0);
        chk("kill_expired_a", {31'd0, a_rdy}, 32'd1);
        chk("kill_kept_b", {31'd0, b_rdy}, 32'd0);
        tick();
        @(negedge clk);
        chk("kill_kept_b2", {31'd0, b_rdy}, 32'd0);
        tick();
        @(negedge clk);
        chk("kill_expired_b", {31'd0, b_rdy}, 32'd1);
        tick();

        // Reload of busy[x5] in the same cycle it decrements from 1
        do_reset();
        f_ir = LW5; f_valid = 1'b1;
        tick();
        @(negedge clk);
        chk("reload_ready", {31'd0, a_rdy}, 32'd1);
        tick();
        f_ir = ADD6;
        @(negedge clk);
        chk("reload_stall", {31'd0, a_rdy}, 32'd0);
        tick();
        @(negedge clk);
        chk("reload_release", {31'd0, a_rdy}, 32'd1);
        tick();

        // Reset during a backpressure stall
        do_reset();
        f_ir = LW5; f_valid = 1'b1;
        tick();
        f_ir = ADD6; x_ready = 1'b0;
        @(negedge clk);
        chk("rs_stall_ready", {31'd0, a_rdy}, 32'd0);
        tick();
        rst_n = 1'b0;
        @(negedge clk);
        chk("rs_in_reset_ready", {31'd0, a_rdy}, 32'd0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rs_xvalid", {31'd0, a_xv}, 32'd0);
        chk("rs_cleared_ready", {31'd0, a_rdy}, 32'd1);
        tick();
        x_ready = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation still running at %0t", $time);
        $fatal(1, "timeout");
    end
endmodule
